// File: rtl/mux_arbiter.sv
// mux_arbiter: N-channel arbiter feeding a single-entry registered output.
// Supports fixed-select and round-robin grant modes with ready/valid flow control.
module mux_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CHANNELS  = 3,
    parameter int unsigned SEL_WIDTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    input  logic                         mode,
    input  logic [SEL_WIDTH-1:0]         select,
    output logic [WIDTH-1:0]             out_data,
    output logic [SEL_WIDTH-1:0]         out_channel,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int unsigned SEL_SPAN = 1 << SEL_WIDTH;
    localparam logic [SEL_WIDTH-1:0] LAST_RST = SEL_WIDTH'(CHANNELS - 1);

    logic [WIDTH-1:0]                r_out_data;
    logic [SEL_WIDTH-1:0]            r_out_channel;
    logic                            r_out_valid;
    logic [SEL_WIDTH-1:0]            r_last;

    logic                            w_load_en;
    logic [SEL_SPAN-1:0]             w_valid_pad;
    logic [SEL_SPAN-1:0][WIDTH-1:0]  w_data_arr;
    logic                            w_fix_grant;
    logic                            w_rr_grant;
    logic [SEL_WIDTH-1:0]            w_rr_idx;
    logic [SEL_WIDTH-1:0]            w_rr_cand;
    logic                            w_grant;
    logic [SEL_WIDTH-1:0]            w_grant_idx;
    logic [CHANNELS-1:0]             w_grant_vec;
    logic [WIDTH-1:0]                w_grant_data;

    // Zero-pad channels to the full select span so out-of-range indices read as idle
    always_comb begin
        w_valid_pad = SEL_SPAN'(in_valid);
        w_data_arr  = (SEL_SPAN * WIDTH)'(in_data);
    end

    // Output register may accept a new word when empty or draining this cycle
    always_comb begin
        w_load_en   = !r_out_valid || out_ready;
        w_fix_grant = w_valid_pad[select];
    end

    // Round-robin search: first valid channel after the last round-robin winner
    always_comb begin
        w_rr_grant = 1'b0;
        w_rr_idx   = '0;
        w_rr_cand  = '0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            w_rr_cand = SEL_WIDTH'((32'(r_last) + k) % CHANNELS);
            if (!w_rr_grant && w_valid_pad[w_rr_cand]) begin
                w_rr_grant = 1'b1;
                w_rr_idx   = w_rr_cand;
            end
        end
    end

    // Final grant decision, one-hot ready vector and selected data
    always_comb begin
        w_grant      = !reset && w_load_en && (mode ? w_rr_grant : w_fix_grant);
        w_grant_idx  = mode ? w_rr_idx : select;
        w_grant_vec  = w_grant ? CHANNELS'(SEL_SPAN'(1) << w_grant_idx) : '0;
        w_grant_data = w_data_arr[w_grant_idx];
    end

    // Output register and round-robin pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_channel <= '0;
            r_last        <= LAST_RST;
        end else if (w_grant) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= w_grant_data;
            r_out_channel <= w_grant_idx;
            if (mode) begin
                r_last <= w_grant_idx;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready    = w_grant_vec;
    assign out_data    = r_out_data;
    assign out_channel = r_out_channel;
    assign out_valid   = r_out_valid;

endmodule
